vc_credit_out_port: RTL and testbench

- Router output-port stage that sits directly upstream of the neighbour router's per-VC FWFT input FIFOs.
- Arbitrates round-robin among V local VC sources. Each source is a FWFT FIFO, so its data is valid while its request is high.
- Tracks per-VC credits so that a downstream FIFO is never written when full.
- Drives one registered flit per cycle onto the link, tagged with a one-hot VC.

---
 rtl/vc_credit_out_port.sv | 121 ++++++++++++
 tb/tb_vc_credit_out_port.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vc_credit_out_port.sv
// Credit-based output port that arbitrates round-robin among V local VC sources.
// Each source is a FWFT FIFO. The port drives one registered flit per cycle onto
// the link and tags it with a one-hot VC. A VC only sends when it holds a credit
// for the downstream FIFO.
// Optional build macro: VC_CREDIT_CHECK_EN enables credit-overflow detection
// through the sticky err_o output.
module vc_credit_out_port #(
  parameter int unsigned V         = 4,
  parameter int unsigned FLIT_W    = 32,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [V-1:0]        req_in,
  input  logic [V*FLIT_W-1:0] flit_in,
  output logic [V-1:0]        grant_out,
  output logic [FLIT_W-1:0]   flit_out,
  output logic                flit_wr,
  output logic [V-1:0]        vc_out,
  input  logic [V-1:0]        credit_in,
  output logic [V-1:0]        credit_avail,
  output logic                err_o
);

  localparam int unsigned CREDIT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W    = (V > 1) ? $clog2(V) : 1;
  localparam int unsigned SUM_W    = PTR_W + 1;

  logic [CREDIT_W-1:0] credit [V];
  logic [PTR_W-1:0]    ptr;
  logic [V-1:0]        eligible;
  logic [PTR_W-1:0]    win;
  logic                found;
  logic [SUM_W-1:0]    cand;
  logic [V-1:0]        ovf;

  // A VC is eligible only with a registered, non-zero credit.
  always_comb begin
    eligible     = '0;
    credit_avail = '0;
    for (int v = 0; v < V; v++) begin
      credit_avail[v] = (credit[v] != '0);
      eligible[v]     = req_in[v] & credit_avail[v];
    end
  end

  // Round-robin search: start at ptr, wrap modulo V, and the first eligible VC wins.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    grant_out = '0;
    for (int i = 0; i < V; i++) begin
      cand = {1'b0, ptr} + SUM_W'(i);
      if (cand >= SUM_W'(V)) cand = cand - SUM_W'(V);
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = cand[PTR_W-1:0];
      end
    end
    if (found && !reset) grant_out[win] = 1'b1;
  end

`ifdef VC_CREDIT_CHECK_EN
  // A return that arrives while the counter is already full and nothing is sent is an overflow.
  always_comb begin
    ovf = '0;
    for (int v = 0; v < V; v++)
      ovf[v] = credit_in[v] & (credit[v] == CREDIT_W'(BUF_DEPTH)) & ~grant_out[v];
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) err_o <= 1'b0;
    else if (ovf != '0) err_o <= 1'b1;
  end

`ifndef SYNTHESIS
  // Report which VC overflowed.
  always_ff @(posedge clk) begin
    if (!reset)
      for (int v = 0; v < V; v++)
        if (ovf[v]) $display("vc_credit_out_port: credit overflow on VC %0d", v);
  end
`endif
`else
  assign ovf   = '0;
  assign err_o = 1'b0;
`endif

  // Per-VC credit counters: a send spends a credit and credit_in returns one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) credit[v] <= CREDIT_W'(BUF_DEPTH);
    end else begin
      for (int v = 0; v < V; v++) begin
        if (ovf[v]) credit[v] <= CREDIT_W'(BUF_DEPTH);
        else credit[v] <= credit[v] - CREDIT_W'(grant_out[v]) + CREDIT_W'(credit_in[v]);
      end
    end
  end

  // Link output register and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out <= '0;
      flit_wr  <= 1'b0;
      vc_out   <= '0;
      ptr      <= '0;
    end else if (found) begin
      flit_out <= flit_in[int'(win)*FLIT_W +: FLIT_W];
      flit_wr  <= 1'b1;
      vc_out   <= grant_out;
      ptr      <= (win == PTR_W'(V - 1)) ? '0 : win + PTR_W'(1);
    end else begin
      flit_wr  <= 1'b0;
      vc_out   <= '0;
    end
  end

endmodule

// File: tb/tb_vc_credit_out_port.sv
// Self-checking bench for vc_credit_out_port: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural credit/RR model.
module tb_vc_credit_out_port;
  localparam int V  = 4;
  localparam int FW = 32;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [V-1:0]    req_in;
  logic [V*FW-1:0] flit_in;
  logic [V-1:0]    grant_out;
  logic [FW-1:0]   flit_out;
  logic            flit_wr;
  logic [V-1:0]    vc_out;
  logic [V-1:0]    credit_in;
  logic [V-1:0]    credit_avail;
  logic            err_o;

  vc_credit_out_port #(.V(V), .FLIT_W(FW), .BUF_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .flit_in(flit_in),
    .grant_out(grant_out), .flit_out(flit_out), .flit_wr(flit_wr),
    .vc_out(vc_out), .credit_in(credit_in), .credit_avail(credit_avail),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int          m_cred [V];
  int          m_ptr;
  logic [FW-1:0] m_flit;
  logic        m_wr;
  logic [V-1:0] m_vc;
  logic        m_err;

  // DUT values captured at the most recent check point.
  logic [V-1:0] cap_grant, cap_vc, cap_avail;
  logic         cap_wr, cap_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [V-1:0] model_grant(input logic [V-1:0] req);
    for (int i = 0; i < V; i++) begin
      int v = (m_ptr + i) % V;
      if (req[v] && m_cred[v] > 0) return V'(1) << v;
    end
    return '0;
  endfunction

  // One clock cycle: drive inputs, check every output at negedge, advance the model.
  task automatic step(input logic rst, input logic [V-1:0] req, input logic [V-1:0] cin);
    logic [V-1:0]    eg;
    logic [V*FW-1:0] fl;
    logic [V-1:0]    ea;
    for (int v = 0; v < V; v++) fl[v*FW +: FW] = $urandom();
    reset = rst; req_in = req; flit_in = fl; credit_in = cin;
    eg = rst ? '0 : model_grant(req);
    @(negedge clk);
    for (int v = 0; v < V; v++) ea[v] = (m_cred[v] != 0);
    cap_grant = grant_out; cap_vc = vc_out; cap_wr = flit_wr;
    cap_avail = credit_avail; cap_err = err_o;
    chk("grant_out", 64'(grant_out), 64'(eg));
    chk("flit_wr", 64'(flit_wr), 64'(m_wr));
    chk("vc_out", 64'(vc_out), 64'(m_vc));
    chk("flit_out", 64'(flit_out), 64'(m_flit));
    chk("credit_avail", 64'(credit_avail), 64'(ea));
    chk("err_o", 64'(err_o), 64'(m_err));
    if (rst) begin
      for (int v = 0; v < V; v++) m_cred[v] = D;
      m_ptr = 0; m_flit = '0; m_wr = 1'b0; m_vc = '0; m_err = 1'b0;
    end else begin
      m_wr = (eg != '0);
      m_vc = eg;
      for (int v = 0; v < V; v++) begin
        if (eg[v]) begin
          m_flit = fl[v*FW +: FW];
          m_ptr  = (v + 1) % V;
        end
`ifdef VC_CREDIT_CHECK_EN
        if (cin[v] && m_cred[v] == D && !eg[v]) m_err = 1'b1;
        else m_cred[v] = m_cred[v] - int'(eg[v]) + int'(cin[v]);
`else
        m_cred[v] = m_cred[v] - int'(eg[v]) + int'(cin[v]);
`endif
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [V-1:0] rq, ci;
    logic [V-1:0] exp_seq [4];
    for (int v = 0; v < V; v++) m_cred[v] = D;
    m_ptr = 0; m_flit = '0; m_wr = 1'b0; m_vc = '0; m_err = 1'b0;
    reset = 1'b1; req_in = '0; flit_in = '0; credit_in = '0;
    @(posedge clk); #1;

    // Single VC drains its four credits, then stalls.
    step(1'b1, 4'b0000, 4'b0000);
    for (int c = 1; c <= 6; c++) begin
      step(1'b0, 4'b0001, 4'b0000);
      chk("t1_grant", 64'(cap_grant), (c <= 4) ? 64'h1 : 64'h0);
      if (c >= 2 && c <= 5) chk("t1_vc", 64'(cap_vc), 64'h1);
    end
    chk("t1_avail", 64'(cap_avail), 64'hE);

    // A credit return lets the stalled VC resend on the following cycle only.
    step(1'b0, 4'b0001, 4'b0001);
    chk("t3_grant_t", 64'(cap_grant), 64'h0);
    step(1'b0, 4'b0001, 4'b0000);
    chk("t3_grant_t1", 64'(cap_grant), 64'h1);
    step(1'b0, 4'b0001, 4'b0000);
    chk("t3_grant_after", 64'(cap_grant), 64'h0);

    // All four VCs requesting are served in rotation, and vc_out trails by one cycle.
    step(1'b1, 4'b0000, 4'b0000);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b1111, 4'b0000);
      chk("t2_grant", 64'(cap_grant), 64'(exp_seq[c % 4]));
      if (c > 0) chk("t2_vc", 64'(cap_vc), 64'(exp_seq[(c - 1) % 4]));
    end

    // A send and a return in the same cycle keep VC2 at one credit.
    step(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0100);
    chk("t4_grant_same", 64'(cap_grant), 64'h4);
    step(1'b0, 4'b0100, 4'b0000);
    chk("t4_grant_next", 64'(cap_grant), 64'h4);
    step(1'b0, 4'b0100, 4'b0000);
    chk("t4_grant_empty", 64'(cap_grant), 64'h0);

    // Reset asserted in the middle of a burst.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    chk("t6_grant_rst", 64'(cap_grant), 64'h0);
    step(1'b0, 4'b1111, 4'b0000);
    chk("t6_wr", 64'(cap_wr), 64'h0);
    chk("t6_vc", 64'(cap_vc), 64'h0);
    chk("t6_avail", 64'(cap_avail), 64'hF);
    chk("t6_first", 64'(cap_grant), 64'h1);

`ifdef VC_CREDIT_CHECK_EN
    // Returning a credit to a full counter sets the sticky error and saturates the count.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0010);
    step(1'b0, 4'b0000, 4'b0000);
    chk("t5_err", 64'(cap_err), 64'h1);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0010, 4'b0000);
    step(1'b0, 4'b0010, 4'b0000);
    chk("t5_sat", 64'(cap_grant), 64'h0);
    chk("t5_sticky", 64'(cap_err), 64'h1);
`else
    chk("t5_noerr", 64'(cap_err), 64'h0);
`endif

    // Randomized traffic: credits are only returned while a downstream slot is occupied.
    step(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      rq = V'($urandom_range(0, 15));
      ci = '0;
      for (int v = 0; v < V; v++)
        if (m_cred[v] < D && $urandom_range(0, 2) != 0) ci[v] = 1'b1;
      step(($urandom_range(0, 299) == 0), rq, ci);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
